icache_waysel_gen: RTL and testbench

- Producer side of the icache way-select interface: compares the four tag-array ways against the ITLB physical tag in S0 and registers the S1 way-select, tag-error, CAM-valid and CAM-miss signals that the icache mutex monitor checks.
- Also owns the single-outstanding miss/fill request FSM, victim-way choice and a saturating multi-hit error counter.
- Sits in the IFU fetch datapath between the tag array/ITLB (S0) and the fetch-select logic (S1).

---
 rtl/icache_waysel_gen.sv | 161 ++++++++++++++++
 tb/tb_icache_waysel_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_waysel_gen.sv
// icache way-select producer: S0 tag compare, S1 way-select/error registers,
// single-outstanding fill FSM with victim choice. Optional parity via ICACHE_WAYSEL_PARITY_EN.
module icache_waysel_gen #(
  parameter int TAG_W = 28,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_vld_s0,
  input  logic                 tlb_cam_vld_s0,
  input  logic                 tlb_cam_hit_s0,
  input  logic [TAG_W-1:0]     tlb_ptag_s0,
  input  logic [4*TAG_W-1:0]   tag_rd_s0,
  input  logic [3:0]           tag_vld_s0,
  input  logic [3:0]           tag_par_s0,
  input  logic                 stall_s1,
  input  logic                 fill_gnt,
  input  logic                 fill_ack,
  output logic [3:0]           waysel_buf_s1,
  output logic [3:0]           alltag_err_s1,
  output logic                 tlb_cam_miss_s1,
  output logic                 cam_vld_s1,
  output logic                 icache_hit_s1,
  output logic                 multihit_err_s1,
  output logic                 fill_req,
  output logic [1:0]           fill_way,
  output logic [TAG_W-1:0]     fill_ptag,
  output logic                 miss_busy,
  output logic [CNT_W-1:0]     multihit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       match_s0;
  logic [3:0]       perr_s0;
  logic [TAG_W-1:0] ptag_s1;
  logic [3:0]       vld_s1;
  logic [1:0]       rr;
  logic             victim_from_rr;
  logic [1:0]       victim_way;
  logic             victim_rr;
  logic             clean_s1;
  logic             miss_s1;
  logic [3:0]       waysel_low_clr;

  // S0 tag compare
  always_comb begin
    match_s0 = '0;
    for (int i = 0; i < 4; i++) begin
      match_s0[i] = tag_vld_s0[i] & (tag_rd_s0[i*TAG_W +: TAG_W] == tlb_ptag_s0);
    end
  end

`ifdef ICACHE_WAYSEL_PARITY_EN
  // Stored bit is even parity: it must equal the XOR of the tag bits.
  always_comb begin
    perr_s0 = '0;
    for (int i = 0; i < 4; i++) begin
      perr_s0[i] = tag_vld_s0[i] & ((^tag_rd_s0[i*TAG_W +: TAG_W]) != tag_par_s0[i]);
    end
  end
`else
  logic unused_tag_par;
  assign unused_tag_par = ^tag_par_s0;
  assign perr_s0        = '0;
`endif

  // S1 pipeline registers; valid bits and ptag are kept for victim choice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waysel_buf_s1   <= '0;
      alltag_err_s1   <= '0;
      cam_vld_s1      <= 1'b0;
      tlb_cam_miss_s1 <= 1'b0;
      ptag_s1         <= '0;
      vld_s1          <= '0;
    end else if (!stall_s1) begin
      waysel_buf_s1   <= match_s0;
      alltag_err_s1   <= perr_s0;
      cam_vld_s1      <= fetch_vld_s0 & tlb_cam_vld_s0;
      tlb_cam_miss_s1 <= tlb_cam_vld_s0 & ~tlb_cam_hit_s0;
      ptag_s1         <= tlb_ptag_s0;
      vld_s1          <= tag_vld_s0;
    end
  end

  assign waysel_low_clr  = waysel_buf_s1 & (waysel_buf_s1 - 4'd1);
  assign clean_s1        = cam_vld_s1 & ~tlb_cam_miss_s1 & (alltag_err_s1 == 4'd0);
  assign icache_hit_s1   = clean_s1 & (waysel_buf_s1 != 4'd0) & (waysel_low_clr == 4'd0);
  assign multihit_err_s1 = clean_s1 & (waysel_low_clr != 4'd0);
  assign miss_s1         = (clean_s1 & (waysel_buf_s1 == 4'd0)) |
                           (cam_vld_s1 & ~tlb_cam_miss_s1 & (|alltag_err_s1));

  // Lowest invalid way wins; round-robin only when every way is valid.
  always_comb begin
    victim_way = rr;
    victim_rr  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (!vld_s1[i]) begin
        victim_way = 2'(i);
        victim_rr  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      fill_req       <= 1'b0;
      fill_way       <= '0;
      fill_ptag      <= '0;
      rr             <= '0;
      victim_from_rr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_s1 && !stall_s1) begin
            state          <= ST_REQ;
            fill_req       <= 1'b1;
            fill_way       <= victim_way;
            fill_ptag      <= ptag_s1;
            victim_from_rr <= victim_rr;
          end
        end
        ST_REQ: begin
          // an ack seen here belongs to no request of ours
          if (fill_gnt) begin
            state    <= ST_WAIT;
            fill_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (fill_ack) begin
            state <= ST_IDLE;
            if (victim_from_rr) rr <= rr + 2'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          fill_req <= 1'b0;
        end
      endcase
    end
  end

  assign miss_busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multihit_cnt <= '0;
    end else if (multihit_err_s1 && !stall_s1 && (multihit_cnt != {CNT_W{1'b1}})) begin
      multihit_cnt <= multihit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_waysel_gen.sv
// Directed bench for icache_waysel_gen; parity expectations follow ICACHE_WAYSEL_PARITY_EN.
module tb_icache_waysel_gen;
  localparam int TAG_W = 28;
  localparam int CNT_W = 8;
  localparam logic [TAG_W-1:0] PTAG = 28'h0ABCDEF;

  logic               clk;
  logic               rst;
  logic               fetch_vld_s0;
  logic               tlb_cam_vld_s0;
  logic               tlb_cam_hit_s0;
  logic [TAG_W-1:0]   tlb_ptag_s0;
  logic [4*TAG_W-1:0] tag_rd_s0;
  logic [3:0]         tag_vld_s0;
  logic [3:0]         tag_par_s0;
  logic               stall_s1;
  logic               fill_gnt;
  logic               fill_ack;
  logic [3:0]         waysel_buf_s1;
  logic [3:0]         alltag_err_s1;
  logic               tlb_cam_miss_s1;
  logic               cam_vld_s1;
  logic               icache_hit_s1;
  logic               multihit_err_s1;
  logic               fill_req;
  logic [1:0]         fill_way;
  logic [TAG_W-1:0]   fill_ptag;
  logic               miss_busy;
  logic [CNT_W-1:0]   multihit_cnt;

  icache_waysel_gen #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_vld_s0(fetch_vld_s0), .tlb_cam_vld_s0(tlb_cam_vld_s0),
    .tlb_cam_hit_s0(tlb_cam_hit_s0), .tlb_ptag_s0(tlb_ptag_s0),
    .tag_rd_s0(tag_rd_s0), .tag_vld_s0(tag_vld_s0), .tag_par_s0(tag_par_s0),
    .stall_s1(stall_s1), .fill_gnt(fill_gnt), .fill_ack(fill_ack),
    .waysel_buf_s1(waysel_buf_s1), .alltag_err_s1(alltag_err_s1),
    .tlb_cam_miss_s1(tlb_cam_miss_s1), .cam_vld_s1(cam_vld_s1),
    .icache_hit_s1(icache_hit_s1), .multihit_err_s1(multihit_err_s1),
    .fill_req(fill_req), .fill_way(fill_way), .fill_ptag(fill_ptag),
    .miss_busy(miss_busy), .multihit_cnt(multihit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tags(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                          input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3);
    tag_rd_s0  = {t3, t2, t1, t0};
    tag_par_s0 = {^t3, ^t2, ^t1, ^t0};
  endtask

  task automatic lookup(input logic [3:0] vld, input logic cam_hit);
    tlb_ptag_s0    = PTAG;
    tag_vld_s0     = vld;
    fetch_vld_s0   = 1'b1;
    tlb_cam_vld_s0 = 1'b1;
    tlb_cam_hit_s0 = cam_hit;
  endtask

  // all ways valid, none match: victim comes from round-robin
  task automatic do_fill();
    logic [1:0] exp_way;
    exp_way = exp_q.pop_front();
    set_tags(PTAG ^ 28'h1, PTAG ^ 28'h2, PTAG ^ 28'h3, PTAG ^ 28'h4);
    lookup(4'b1111, 1'b1);
    tick();
    fetch_vld_s0 = 1'b0;
    tick();
    check("rr_fill_req", 32'(fill_req), 32'd1);
    check("rr_fill_way", 32'(fill_way), 32'(exp_way));
    fill_gnt = 1'b1;
    tick();
    fill_gnt = 1'b0;
    check("rr_wait_busy", 32'(miss_busy), 32'd1);
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check("rr_done_busy", 32'(miss_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_vld_s0 = 1'b0; tlb_cam_vld_s0 = 1'b0; tlb_cam_hit_s0 = 1'b0;
    tlb_ptag_s0 = '0; tag_rd_s0 = '0; tag_vld_s0 = '0; tag_par_s0 = '0;
    stall_s1 = 1'b0; fill_gnt = 1'b0; fill_ack = 1'b0;
    tick();
    tick();
    check("rst_waysel", 32'(waysel_buf_s1), 32'd0);
    check("rst_fill_req", 32'(fill_req), 32'd0);
    check("rst_busy", 32'(miss_busy), 32'd0);
    check("rst_cnt", 32'(multihit_cnt), 32'd0);
    check("rst_fill_ptag", 32'(fill_ptag), 32'd0);
    rst = 1'b0;
    tick();

    // clean hit on way 2
    set_tags(PTAG ^ 28'h1, PTAG ^ 28'h2, PTAG, PTAG ^ 28'h4);
    lookup(4'b1111, 1'b1);
    tick();
    check("hit_waysel", 32'(waysel_buf_s1), 32'h4);
    check("hit_hit", 32'(icache_hit_s1), 32'd1);
    check("hit_multi", 32'(multihit_err_s1), 32'd0);
    fetch_vld_s0 = 1'b0;
    tick();
    check("hit_fill_req", 32'(fill_req), 32'd0);

    // miss; way 1 holds the tag but is invalid, so it is also the victim
    set_tags(PTAG ^ 28'h1, PTAG, PTAG ^ 28'h3, PTAG ^ 28'h4);
    lookup(4'b1101, 1'b1);
    tick();
    check("miss_waysel", 32'(waysel_buf_s1), 32'd0);
    check("miss_hit", 32'(icache_hit_s1), 32'd0);
    fetch_vld_s0 = 1'b0;
    tick();
    check("miss_fill_req", 32'(fill_req), 32'd1);
    check("miss_fill_way", 32'(fill_way), 32'd1);
    check("miss_fill_ptag", 32'(fill_ptag), 32'(PTAG));
    check("miss_busy", 32'(miss_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      fill_ack = (i == 1);
      tick();
      check("req_hold", 32'(fill_req), 32'd1);
    end
    fill_ack = 1'b0;
    fill_gnt = 1'b1;
    fill_ack = 1'b1;
    tick();
    fill_gnt = 1'b0;
    fill_ack = 1'b0;
    check("gnt_drop_req", 32'(fill_req), 32'd0);
    check("gnt_ack_ignored", 32'(miss_busy), 32'd1);
    check("wait_way_stable", 32'(fill_way), 32'd1);
    tick();
    check("wait_hold", 32'(miss_busy), 32'd1);
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check("ack_idle", 32'(miss_busy), 32'd0);

    // ways 0 and 3 both match
    set_tags(PTAG, PTAG ^ 28'h2, PTAG ^ 28'h3, PTAG);
    lookup(4'b1111, 1'b1);
    tick();
    check("mh_waysel", 32'(waysel_buf_s1), 32'h9);
    check("mh_err", 32'(multihit_err_s1), 32'd1);
    check("mh_hit", 32'(icache_hit_s1), 32'd0);
    check("mh_cnt0", 32'(multihit_cnt), 32'd0);
    tick();
    check("mh_cnt1", 32'(multihit_cnt), 32'd1);
    check("mh_no_fill", 32'(fill_req), 32'd0);
    for (int i = 0; i < 300; i++) tick();
    check("mh_cnt_sat", 32'(multihit_cnt), 32'd255);
    fetch_vld_s0 = 1'b0;
    tick();
    tick();
    check("mh_cnt_hold", 32'(multihit_cnt), 32'd255);

    // stall holds S1 while S0 presents something different
    set_tags(PTAG ^ 28'h1, PTAG ^ 28'h2, PTAG, PTAG ^ 28'h4);
    lookup(4'b1111, 1'b1);
    tick();
    check("pre_stall_waysel", 32'(waysel_buf_s1), 32'h4);
    stall_s1 = 1'b1;
    set_tags(PTAG, PTAG, PTAG ^ 28'h3, PTAG ^ 28'h4);
    lookup(4'b0011, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_waysel", 32'(waysel_buf_s1), 32'h4);
      check("stall_hit", 32'(icache_hit_s1), 32'd1);
      check("stall_cam_miss", 32'(tlb_cam_miss_s1), 32'd0);
    end
    stall_s1 = 1'b0;
    fetch_vld_s0 = 1'b0;
    tick();

    // ITLB miss: no fill
    set_tags(PTAG ^ 28'h1, PTAG ^ 28'h2, PTAG ^ 28'h3, PTAG ^ 28'h4);
    lookup(4'b1111, 1'b0);
    tick();
    check("cam_miss", 32'(tlb_cam_miss_s1), 32'd1);
    check("cam_vld", 32'(cam_vld_s1), 32'd1);
    check("cam_miss_hit", 32'(icache_hit_s1), 32'd0);
    fetch_vld_s0 = 1'b0;
    tick();
    check("cam_miss_no_fill", 32'(fill_req), 32'd0);
    check("cam_miss_busy", 32'(miss_busy), 32'd0);

    // round-robin victims with all ways valid
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int i = 0; i < 5; i++) do_fill();

    // way 0 matches but its stored parity is flipped
    set_tags(PTAG, PTAG ^ 28'h2, PTAG ^ 28'h3, PTAG ^ 28'h4);
    tag_par_s0[0] = ~tag_par_s0[0];
    lookup(4'b1111, 1'b1);
    tick();
    check("par_waysel", 32'(waysel_buf_s1), 32'h1);
`ifdef ICACHE_WAYSEL_PARITY_EN
    check("par_err", 32'(alltag_err_s1), 32'h1);
    check("par_hit", 32'(icache_hit_s1), 32'd0);
    fetch_vld_s0 = 1'b0;
    tick();
    check("par_fill_req", 32'(fill_req), 32'd1);
    check("par_fill_way", 32'(fill_way), 32'd1);
    fill_gnt = 1'b1;
    tick();
    fill_gnt = 1'b0;
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check("par_done", 32'(miss_busy), 32'd0);
`else
    check("par_err", 32'(alltag_err_s1), 32'h0);
    check("par_hit", 32'(icache_hit_s1), 32'd1);
    fetch_vld_s0 = 1'b0;
    tick();
    check("par_no_fill", 32'(fill_req), 32'd0);
`endif

    // reset in WAIT clears the FSM at once
    set_tags(PTAG ^ 28'h1, PTAG ^ 28'h2, PTAG ^ 28'h3, PTAG ^ 28'h4);
    lookup(4'b1111, 1'b1);
    tick();
    fetch_vld_s0 = 1'b0;
    tick();
    check("rstw_req", 32'(fill_req), 32'd1);
    fill_gnt = 1'b1;
    tick();
    fill_gnt = 1'b0;
    check("rstw_wait", 32'(miss_busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstw_fill_req", 32'(fill_req), 32'd0);
    check("rstw_busy", 32'(miss_busy), 32'd0);
    check("rstw_cnt", 32'(multihit_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(2'd0);
    do_fill();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
